// File: rtl/mskg_arb.sv
// Purpose: round-robin arbiter that lets two requesters share one clocked field-mask generator.
// Latency: req sampled at edge N -> gnt during N..N+1 -> done/result/err during N+1..N+2; one field per 3 cycles.
// Backpressure: the loser's level request stays pending and is served from the next IDLE; in-flight fields are latched at grant.
module mskg_arb (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [4:0]  pos_a,
    input  logic [4:0]  pos_b,
    input  logic [5:0]  len_a,
    input  logic [5:0]  len_b,
    input  logic [31:0] msk,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        done_a,
    output logic        done_b,
    output logic [31:0] result,
    output logic        err,
    output logic        busy,
    output logic [4:0]  mskl,
    output logic [4:0]  mskr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        win_b;      // winner of the operation in flight (1 = B)
    logic        last_b;     // last served requester (1 = B)
    logic        ill_q;      // latched legality of the in-flight field
    logic        err_q;      // err value captured with result

    logic        start;
    logic        sel_b;
    logic [4:0]  sel_pos;
    logic [5:0]  sel_len;
    logic [6:0]  sum7;
    logic        sel_ill;
    logic [4:0]  end5;
    logic [4:0]  mskl_nxt;

    // Winner select, legality check and left-edge address for the field about to be granted
    always_comb begin
        start    = (state == IDLE) && (req_a || req_b);
        // B wins when alone, or on a tie when A was the last one served
        sel_b    = req_b && (!req_a || !last_b);
        sel_pos  = sel_b ? pos_b : pos_a;
        sel_len  = sel_b ? len_b : len_a;
        sum7     = {2'b00, sel_pos} + {1'b0, sel_len};
        sel_ill  = (sel_len == 6'd0) || (sel_len > 6'd32) || (sum7 > 7'd32);
        // Exact for every legal field (pos+len-1 <= 31, incl. pos=0/len=32)
        end5     = sel_pos + sel_len[4:0] - 5'd1;
        // Illegal fields never wrap: zero length points at pos, overruns clamp to bit 31
        if (!sel_ill)
            mskl_nxt = end5;
        else if (sel_len == 6'd0)
            mskl_nxt = sel_pos;
        else
            mskl_nxt = 5'd31;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state: one cycle each in ISSUE and DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant-time latching: winner, pointer, PROM addresses and legality
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_b  <= 1'b0;
            last_b <= 1'b1;
            ill_q  <= 1'b0;
            mskl   <= 5'd0;
            mskr   <= 5'd0;
        end else if (start) begin
            win_b  <= sel_b;
            last_b <= sel_b;
            ill_q  <= sel_ill;
            mskl   <= mskl_nxt;
            mskr   <= sel_pos;
        end
    end

    // Result capture on the ISSUE->DONE edge; msk has settled on the falling edge inside ISSUE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result <= 32'd0;
            err_q  <= 1'b0;
        end else if (state == ISSUE) begin
            result <= ill_q ? 32'd0 : msk;
            err_q  <= ill_q;
        end
    end

    // Pulse outputs decoded from state and the latched winner
    always_comb begin
        busy   = (state != IDLE);
        gnt_a  = (state == ISSUE) && !win_b;
        gnt_b  = (state == ISSUE) &&  win_b;
        done_a = (state == DONE)  && !win_b;
        done_b = (state == DONE)  &&  win_b;
        err    = (state == DONE)  &&  err_q;
    end

endmodule

// File: tb/tb_mskg_arb.sv
// Purpose: directed bench for mskg_arb with a falling-edge PROM model and a result scoreboard.
// Latency: expects gnt one cycle and done two cycles after the request is driven.
// Backpressure: exercises ties, pending requests and reset aborts.
module tb_mskg_arb;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_a   = 1'b0;
    logic        req_b   = 1'b0;
    logic [4:0]  pos_a   = 5'd0;
    logic [4:0]  pos_b   = 5'd0;
    logic [5:0]  len_a   = 6'd0;
    logic [5:0]  len_b   = 6'd0;
    logic [31:0] msk     = 32'd0;
    logic        gnt_a, gnt_b, done_a, done_b, err, busy;
    logic [31:0] result;
    logic [4:0]  mskl, mskr;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          who_b;
        logic [31:0] res;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_res = 32'd0;

    mskg_arb dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req_a   (req_a),
        .req_b   (req_b),
        .pos_a   (pos_a),
        .pos_b   (pos_b),
        .len_a   (len_a),
        .len_b   (len_b),
        .msk     (msk),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .done_a  (done_a),
        .done_b  (done_b),
        .result  (result),
        .err     (err),
        .busy    (busy),
        .mskl    (mskl),
        .mskr    (mskr)
    );

    always #5 clk = ~clk;

    // PROM pair model: bits mskr..mskl set, clocked on the falling edge
    always @(negedge clk) begin
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 32; i++)
            if (i >= int'(mskr) && i <= int'(mskl)) m[i] = 1'b1;
        msk <= m;
    end

    function automatic logic ref_ill(int p, int l);
        return (l < 1) || (l > 32) || (p + l > 32);
    endfunction

    function automatic logic [31:0] ref_mask(int p, int l);
        logic [31:0] m;
        m = 32'd0;
        if (!ref_ill(p, l))
            for (int i = 0; i < 32; i++)
                if (i >= p && i < p + l) m[i] = 1'b1;
        return m;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_req(bit b, logic v);
        if (b) req_b = v; else req_a = v;
    endtask

    task automatic set_fld(bit b, int p, int l);
        if (b) begin pos_b = p[4:0]; len_b = l[5:0]; end
        else   begin pos_a = p[4:0]; len_a = l[5:0]; end
    endtask

    task automatic push(bit b, int p, int l);
        exp_t e;
        e.who_b = b;
        e.res   = ref_mask(p, l);
        e.err   = ref_ill(p, l);
        sb.push_back(e);
    endtask

    // Wait (bounded) for a done pulse, then pop and compare against the scoreboard
    task automatic score(string tag, int exp_lat);
        int   lat;
        bit   seen;
        exp_t e;
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 6 && !seen; i++) begin
            @(negedge clk);
            if (done_a || done_b) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_latency"}, lat, exp_lat);
            check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({tag, "_done_a"}, 32'(done_a), 32'(!e.who_b));
                check({tag, "_done_b"}, 32'(done_b), 32'(e.who_b));
                check({tag, "_result"}, result, e.res);
                check({tag, "_err"},    32'(err), 32'(e.err));
                check({tag, "_gnt_low"}, 32'(gnt_a | gnt_b), 32'd0);
                last_res = e.res;
            end
        end
    endtask

    // Checks for the IDLE cycle following DONE: pulses low, result held
    task automatic idle_checks(string tag);
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_pulses"}, 32'({gnt_a, gnt_b, done_a, done_b, err}), 32'd0);
        check({tag, "_idle_hold"}, result, last_res);
    endtask

    // One request from a single requester; chg rewrites its fields during ISSUE
    task automatic run_single(string tag, bit b, int p, int l, bit chk_addr, bit chg);
        set_fld(b, p, l);
        set_req(b, 1'b1);
        push(b, p, l);
        @(negedge clk);
        check({tag, "_gnt"},   32'({gnt_a, gnt_b}), b ? 32'd1 : 32'd2);
        check({tag, "_busy"},  32'(busy), 32'd1);
        check({tag, "_mskr"},  32'(mskr), p);
        if (chk_addr)
            check({tag, "_mskl"}, 32'(mskl), p + l - 1);
        if (chg)
            set_fld(b, 0, 1);
        score(tag, 1);
        set_req(b, 1'b0);
        idle_checks(tag);
    endtask

    // Both request together; first_b names the requester round-robin should pick first
    task automatic tie(string tag, bit first_b, int p1, int l1, int p2, int l2);
        set_fld(first_b, p1, l1);
        set_fld(!first_b, p2, l2);
        req_a = 1'b1;
        req_b = 1'b1;
        push(first_b, p1, l1);
        push(!first_b, p2, l2);
        @(negedge clk);
        check({tag, "_gnt_first"}, 32'({gnt_a, gnt_b}), first_b ? 32'd1 : 32'd2);
        score({tag, "_first"}, 1);
        set_req(first_b, 1'b0);
        @(negedge clk);
        check({tag, "_gap_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_gnt_second"}, 32'({gnt_a, gnt_b}), first_b ? 32'd2 : 32'd1);
        score({tag, "_second"}, 1);
        set_req(!first_b, 1'b0);
        idle_checks(tag);
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_outputs", 32'({gnt_a, gnt_b, done_a, done_b, err, busy}), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_mskl", 32'(mskl), 32'd0);
        check("rst_mskr", 32'(mskr), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Tie out of reset: A first, B served after A's DONE
        tie("tie1", 1'b0, 8, 8, 0, 32);

        // Single A: pos 8 len 8 -> 0x0000FF00 (pointer now A)
        run_single("a_8_8", 1'b0, 8, 8, 1'b1, 1'b0);

        // Tie with A served last: B first, then A
        tie("tie2", 1'b1, 31, 1, 0, 32);

        // Boundary fields
        run_single("b_0_32", 1'b1, 0, 32, 1'b1, 1'b0);
        run_single("a_31_1", 1'b0, 31, 1, 1'b1, 1'b0);
        run_single("b_3_5",  1'b1, 3, 5, 1'b1, 1'b0);

        // Illegal fields: same timing, err=1, result 0
        run_single("ill_28_8", 1'b0, 28, 8, 1'b0, 1'b0);
        run_single("ill_len0", 1'b1, 5, 0, 1'b0, 1'b0);
        run_single("ill_len33", 1'b0, 0, 33, 1'b0, 1'b0);

        // Field change during ISSUE does not disturb the op in flight
        run_single("chg_4_4", 1'b0, 4, 4, 1'b1, 1'b1);

        // Reset pulse during ISSUE aborts with no done
        set_fld(1'b0, 4, 4);
        req_a = 1'b1;
        @(negedge clk);
        check("abort_gnt", 32'(gnt_a), 32'd1);
        #1 reset_n = 1'b0;
        req_a = 1'b0;
        #1;
        check("abort_outputs", 32'({gnt_a, gnt_b, done_a, done_b, err, busy}), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_mskl", 32'(mskl), 32'd0);
        check("abort_mskr", 32'(mskr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        last_res = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'({done_a, done_b, busy}), 32'd0);
        end
        run_single("post_rst", 1'b0, 2, 6, 1'b1, 1'b0);

        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
